// File: rtl/debounce_if.sv
// debounce_if: groups the switch input, settle-counter handshake, and filtered outputs of debounce_fsm
//   master: drives noisy_in, delay, clr_counts; observes the outputs
//   slave : the debouncer; receives the inputs and drives enable, clean_out, rise_pulse, fall_pulse, press_count, glitch_count
interface debounce_if #(parameter int CNT_W = 8);
  logic             noisy_in;
  logic             delay;
  logic             clr_counts;
  logic             enable;
  logic             clean_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] press_count;
  logic [CNT_W-1:0] glitch_count;
  modport master (
    output noisy_in, delay, clr_counts,
    input  enable, clean_out, rise_pulse, fall_pulse, press_count, glitch_count
  );
  modport slave (
    input  noisy_in, delay, clr_counts,
    output enable, clean_out, rise_pulse, fall_pulse, press_count, glitch_count
  );
endinterface

// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronises a raw switch, filters bounce against an external settle counter, reports clean level, edges and statistics
//   clk, rst   : clock and synchronous active-high reset
//   bus_if     : noisy_in, delay (counter terminal), clr_counts in; enable (to counter), clean_out,
//                rise_pulse, fall_pulse, press_count, glitch_count out
module debounce_fsm #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst,
  debounce_if.slave bus_if
);
  typedef enum logic [1:0] {LOW = 2'd0, WAIT_H = 2'd1, HIGH = 2'd2, WAIT_L = 2'd3} state_e;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw, abort, rise_d, fall_d, clean_d;
  logic                   clean_q, rise_q, fall_q;
  logic [CNT_W-1:0]       press_q, press_d, glitch_q, glitch_d;
  assign sw = sync_q[SYNC_STAGES-1];
  // an abort (sw reverting) is checked before delay so it always wins the same cycle
  always_comb begin
    state_d = LOW;
    case (state_q)
      LOW:     state_d = sw ? WAIT_H : LOW;
      WAIT_H:  state_d = !sw ? LOW : bus_if.delay ? HIGH : WAIT_H;
      HIGH:    state_d = sw ? HIGH : WAIT_L;
      WAIT_L:  state_d = sw ? HIGH : bus_if.delay ? LOW : WAIT_L;
      default: state_d = LOW;
    endcase
  end
  assign abort    = (state_q == WAIT_H && !sw) || (state_q == WAIT_L && sw);
  assign rise_d   = state_q == WAIT_H && state_d == HIGH;
  assign fall_d   = state_q == WAIT_L && state_d == LOW;
  assign clean_d  = state_d == HIGH || state_d == WAIT_L;
  assign press_d  = bus_if.clr_counts ? '0 : (rise_d && press_q != '1) ? press_q + ONE : press_q;
  assign glitch_d = bus_if.clr_counts ? '0 : (abort && glitch_q != '1) ? glitch_q + ONE : glitch_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= LOW;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      press_q  <= '0;
      glitch_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus_if.noisy_in};
      state_q  <= state_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      press_q  <= press_d;
      glitch_q <= glitch_d;
    end
  end
  // decoded from the state register so every WAIT exit gives the counter a cleared cycle
  assign bus_if.enable       = state_q == WAIT_H || state_q == WAIT_L;
  assign bus_if.clean_out    = clean_q;
  assign bus_if.rise_pulse   = rise_q;
  assign bus_if.fall_pulse   = fall_q;
  assign bus_if.press_count  = press_q;
  assign bus_if.glitch_count = glitch_q;
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: table vectors, timed corner sequences and randomized traffic against a level/settling reference model
module tb_debounce_fsm;
  localparam int CW  = 4;
  localparam int SS  = 2;
  localparam int MAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  debounce_if #(.CNT_W(CW)) bus ();
  debounce_fsm #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (.clk(clk), .rst(rst), .bus_if(bus));
  logic        use_stub = 1'b1;
  logic        stub_dly = 1'b0;
  int          n_term   = 50;
  logic [15:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || !bus.enable) ? 16'd0 : cnt + 16'd1;
  assign bus.delay = use_stub ? stub_dly : (cnt == 16'(n_term));
  int vecs = 0;
  int errs = 0;
  int n_rise, n_fall, n_en, n_cl;
  bit m_set, m_clean, m_rise, m_fall;
  int m_pc, m_gc;
  bit mq[$];
  typedef struct packed {
    logic r, n, d, c;
    logic en, cl, ri, fa;
    logic [3:0] pc, gc;
  } vec_t;
  vec_t tbl[28];
  function automatic logic [31:0] dword();
    return 32'({bus.enable, bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.press_count, bus.glitch_count});
  endfunction
  function automatic logic [31:0] mword();
    return 32'({m_set, m_clean, m_rise, m_fall, CW'(m_pc), CW'(m_gc)});
  endfunction
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  // Reference: the debounced level plus a "settling toward the other level" flag
  task automatic step(input string nm);
    bit d, nz, c, r, sw;
    #2;
    d  = bus.delay;
    nz = bus.noisy_in;
    c  = bus.clr_counts;
    r  = rst;
    @(posedge clk);
    if (r) begin
      mq = {};
      repeat (SS) mq.push_back(1'b0);
      {m_set, m_clean, m_rise, m_fall} = '0;
      m_pc = 0;
      m_gc = 0;
    end else begin
      sw     = mq[$];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_set) begin
        if (sw == m_clean) begin
          m_set = 1'b0;
          if (m_gc < MAX) m_gc++;
        end else if (d) begin
          m_set   = 1'b0;
          m_clean = !m_clean;
          m_rise  = m_clean;
          m_fall  = !m_clean;
          if (m_rise && m_pc < MAX) m_pc++;
        end
      end else m_set = (sw != m_clean);
      if (c) begin
        m_pc = 0;
        m_gc = 0;
      end
      mq.push_front(nz);
      void'(mq.pop_back());
    end
    #1;
    cmp(nm, dword(), mword());
    n_rise += int'(bus.rise_pulse);
    n_fall += int'(bus.fall_pulse);
    n_en   += int'(bus.enable);
    n_cl   += int'(bus.clean_out);
  endtask
  task automatic run(input int n);
    repeat (n) step("model");
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    bus.noisy_in = 1'b0;
    run(5);
    {n_rise, n_fall, n_en, n_cl} = '0;
  endtask
  initial begin
    int first, g0, hold;
    bus.noisy_in   = 1'b0;
    bus.clr_counts = 1'b0;
    tbl = '{
      16'b1000_0000_0000_0000, 16'b1000_0000_0000_0000, 16'b0100_0000_0000_0000, 16'b0010_0000_0000_0000,
      16'b0000_1000_0000_0000, 16'b0010_0000_0000_0001, 16'b0100_0000_0000_0001, 16'b0100_0000_0000_0001,
      16'b0100_1000_0000_0001, 16'b0110_0110_0001_0001, 16'b0110_0100_0001_0001, 16'b0000_0100_0001_0001,
      16'b0000_0100_0001_0001, 16'b0100_1100_0001_0001, 16'b0110_0001_0001_0001, 16'b0100_1000_0001_0001,
      16'b0000_1000_0001_0001, 16'b0110_0110_0010_0001, 16'b0000_1100_0010_0001, 16'b0010_0100_0010_0010,
      16'b0000_1100_0010_0010, 16'b0001_1100_0000_0000, 16'b0010_0001_0000_0000, 16'b0010_0000_0000_0000,
      16'b0100_0000_0000_0000, 16'b0100_0000_0000_0000, 16'b0100_1000_0000_0000, 16'b1110_0000_0000_0000
    };
    for (int i = 0; i < 28; i++) begin
      rst            = tbl[i].r;
      bus.noisy_in   = tbl[i].n;
      stub_dly       = tbl[i].d;
      bus.clr_counts = tbl[i].c;
      step("model");
      cmp($sformatf("tbl%0d", i), dword(),
          32'({tbl[i].en, tbl[i].cl, tbl[i].ri, tbl[i].fa, tbl[i].pc, tbl[i].gc}));
    end
    {rst, stub_dly, bus.clr_counts, use_stub} = '0;
    n_term = 50;
    do_reset();
    bus.noisy_in = 1'b1;
    first = -1;
    for (int j = 0; j <= 60; j++) begin
      step("model");
      if (bus.clean_out && first < 0) first = j;
    end
    cmp("t1_latency", 32'(first), 32'd53);
    cmp("t1_enable_cycles", 32'(n_en), 32'd51);
    cmp("t1_rise_pulses", 32'(n_rise), 32'd1);
    cmp("t1_counts", 32'({bus.press_count, bus.glitch_count}), 32'({4'd1, 4'd0}));
    do_reset();
    repeat (3) begin
      bus.noisy_in = 1'b1;
      run(10);
      bus.noisy_in = 1'b0;
      run(5);
    end
    bus.noisy_in = 1'b1;
    run(70);
    cmp("t2_counts", 32'({bus.press_count, bus.glitch_count}), 32'({4'd1, 4'd3}));
    cmp("t2_rise_pulses", 32'(n_rise), 32'd1);
    cmp("t2_clean", 32'(bus.clean_out), 32'd1);
    {n_rise, n_fall} = '0;
    bus.noisy_in = 1'b0;
    run(100);
    cmp("t3_fall_pulses", 32'(n_fall), 32'd1);
    cmp("t3_rise_pulses", 32'(n_rise), 32'd0);
    cmp("t3_clean_press", 32'({bus.clean_out, bus.press_count}), 32'({1'b0, 4'd1}));
    bus.noisy_in = 1'b1;
    run(60);
    g0 = int'(bus.glitch_count);
    {n_rise, n_fall, n_cl} = '0;
    bus.noisy_in = 1'b0;
    run(10);
    bus.noisy_in = 1'b1;
    run(1);
    bus.noisy_in = 1'b0;
    run(20);
    cmp("t3_blip_glitch", 32'(bus.glitch_count), 32'(g0 + 1));
    cmp("t3_blip_pulses", 32'(n_rise + n_fall), 32'd0);
    cmp("t3_blip_clean_cycles", 32'(n_cl), 32'd31);
    do_reset();
    repeat (18) begin
      bus.noisy_in = 1'b1;
      run(5);
      bus.noisy_in = 1'b0;
      run(5);
    end
    cmp("t5_glitch_sat", 32'(bus.glitch_count), 32'(MAX));
    do_reset();
    repeat (20) begin
      bus.noisy_in = 1'b1;
      run(60);
      bus.noisy_in = 1'b0;
      run(60);
    end
    cmp("t5_press_sat", 32'(bus.press_count), 32'(MAX));
    bus.noisy_in = 1'b1;
    run(53);
    bus.clr_counts = 1'b1;
    step("model");
    cmp("t5_clr_vs_rise", 32'({bus.rise_pulse, bus.press_count}), 32'({1'b1, 4'd0}));
    bus.clr_counts = 1'b0;
    step("model");
    cmp("t5_after_clr", 32'({bus.rise_pulse, bus.press_count}), 32'({1'b0, 4'd0}));
    do_reset();
    bus.noisy_in = 1'b1;
    run(32);
    cmp("t6_in_wait_h", 32'({bus.enable, bus.clean_out}), 32'({1'b1, 1'b0}));
    rst = 1'b1;
    step("model");
    cmp("t6_reset_outputs", dword(), 32'd0);
    rst = 1'b0;
    first = -1;
    for (int j = 1; j <= 80; j++) begin
      step("model");
      if (bus.clean_out && first < 0) first = j;
    end
    cmp("t6_resettle", 32'(first), 32'd54);
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        bus.noisy_in = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 199) == 0) begin
        use_stub = !use_stub;
        n_term   = int'($urandom_range(1, 8));
      end
      stub_dly       = ($urandom_range(0, 3) == 0);
      bus.clr_counts = ($urandom_range(0, 79) == 0);
      rst            = ($urandom_range(0, 399) == 0);
      step("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
